voice_update_scheduler: RTL and testbench

- Sits between spi_controller and the time-multiplexed voice engine.
- Captures each completed SPI note event (note-on/off, voice index, tuning code, velocity) into a small FIFO.
- Replays each event as a one-cycle write into the voice parameter bank, only during that voice's own engine slot, so a voice's phase/tuning state is never torn mid-slot.
- Maintains the per-voice gate mask and overflow/error status.

---
 rtl/voice_update_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_voice_update_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_update_scheduler.sv
// Queues SPI note events and replays each one into the voice parameter bank
// during the target voice's own engine slot, tracking gates and drop status.
module voice_update_scheduler #(
  parameter int NUM_VOICES = 16,
  parameter int VOICE_W    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TUNING_W   = 32
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_SPI_flag,
  input  logic                             i_SPI_note_status,
  input  logic [7:0]                       i_SPI_voice_index,
  input  logic [TUNING_W-1:0]              i_SPI_tuning_code,
  input  logic [6:0]                       i_SPI_velocity,
  input  logic                             i_slot_valid,
  input  logic [VOICE_W-1:0]               i_slot_voice,
  output logic                             o_wr_en,
  output logic [VOICE_W-1:0]               o_wr_voice,
  output logic [TUNING_W-1:0]              o_wr_tuning,
  output logic [6:0]                       o_wr_velocity,
  output logic                             o_wr_gate,
  output logic [NUM_VOICES-1:0]            o_gate_mask,
  output logic [$clog2(FIFO_DEPTH):0]      o_fifo_level,
  output logic                             o_overflow,
  output logic                             o_slot_err,
  output logic [7:0]                       o_drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NUM_VOICES + 2);
  localparam logic [8:0]       NUM_VOICES_9 = 9'(NUM_VOICES);
  localparam logic [LVL_W-1:0] LVL_FULL     = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TMO_LOAD     = CNT_W'(NUM_VOICES + 1);

  typedef struct packed {
    logic [VOICE_W-1:0]  voice;
    logic [TUNING_W-1:0] tuning;
    logic [6:0]          velocity;
    logic                gate;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SLOT = 2'd1,
    S_WRITE     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   flag_q, flag_d;
  entry_t                 fifo_q [FIFO_DEPTH];
  entry_t                 fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  entry_t                 hold_q, hold_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic                   wr_en_q, wr_en_d;
  logic [VOICE_W-1:0]     wr_voice_q, wr_voice_d;
  logic [TUNING_W-1:0]    wr_tuning_q, wr_tuning_d;
  logic [6:0]             wr_velocity_q, wr_velocity_d;
  logic                   wr_gate_q, wr_gate_d;
  logic [NUM_VOICES-1:0]  gate_mask_q, gate_mask_d;
  logic                   overflow_q, overflow_d;
  logic                   slot_err_q, slot_err_d;
  logic [7:0]             drop_count_q, drop_count_d;

  logic   edge_det, idx_ok, fifo_full, pop, push, drop_full, drop;
  entry_t entry_in;

  assign edge_det  = i_SPI_flag & ~flag_q;
  assign idx_ok    = ({1'b0, i_SPI_voice_index} < NUM_VOICES_9);
  assign fifo_full = (level_q == LVL_FULL);
  assign pop       = (state_q == S_IDLE) && (level_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = edge_det & idx_ok & (~fifo_full | pop);
  assign drop_full = edge_det & idx_ok & fifo_full & ~pop;
  assign drop      = edge_det & (~idx_ok | drop_full);

  always_comb begin
    entry_in          = '0;
    entry_in.voice    = i_SPI_voice_index[VOICE_W-1:0];
    entry_in.gate     = i_SPI_note_status;
    entry_in.tuning   = i_SPI_note_status ? i_SPI_tuning_code : '0;
    entry_in.velocity = i_SPI_note_status ? i_SPI_velocity : '0;
  end

  always_comb begin
    state_d       = state_q;
    flag_d        = i_SPI_flag;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    level_d       = level_q;
    hold_d        = hold_q;
    tmo_d         = tmo_q;
    wr_en_d       = 1'b0;
    wr_voice_d    = wr_voice_q;
    wr_tuning_d   = wr_tuning_q;
    wr_velocity_d = wr_velocity_q;
    wr_gate_d     = wr_gate_q;
    gate_mask_d   = gate_mask_q;
    overflow_d    = overflow_q | drop_full;
    slot_err_d    = slot_err_q;
    drop_count_d  = drop_count_q;

    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = entry_in;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          hold_d  = fifo_q[rd_ptr_q];
          tmo_d   = TMO_LOAD;
          state_d = S_WAIT_SLOT;
        end
      end
      S_WAIT_SLOT: begin
        if (i_slot_valid) begin
          tmo_d = tmo_q - CNT_W'(1);
          // Terminal count: this pulse is the (NUM_VOICES+1)th without a match.
          if ((i_slot_voice == hold_q.voice) || (tmo_q == CNT_W'(1))) begin
            if (i_slot_voice != hold_q.voice) begin
              slot_err_d = 1'b1;
            end
            wr_en_d       = 1'b1;
            wr_voice_d    = hold_q.voice;
            wr_tuning_d   = hold_q.tuning;
            wr_velocity_d = hold_q.velocity;
            wr_gate_d     = hold_q.gate;
            state_d       = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        gate_mask_d[hold_q.voice] = hold_q.gate;
        state_d                   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      flag_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      hold_q        <= '0;
      tmo_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_voice_q    <= '0;
      wr_tuning_q   <= '0;
      wr_velocity_q <= '0;
      wr_gate_q     <= 1'b0;
      gate_mask_q   <= '0;
      overflow_q    <= 1'b0;
      slot_err_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      flag_q        <= flag_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
      wr_en_q       <= wr_en_d;
      wr_voice_q    <= wr_voice_d;
      wr_tuning_q   <= wr_tuning_d;
      wr_velocity_q <= wr_velocity_d;
      wr_gate_q     <= wr_gate_d;
      gate_mask_q   <= gate_mask_d;
      overflow_q    <= overflow_d;
      slot_err_q    <= slot_err_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign o_wr_en       = wr_en_q;
  assign o_wr_voice    = wr_voice_q;
  assign o_wr_tuning   = wr_tuning_q;
  assign o_wr_velocity = wr_velocity_q;
  assign o_wr_gate     = wr_gate_q;
  assign o_gate_mask   = gate_mask_q;
  assign o_fifo_level  = level_q;
  assign o_overflow    = overflow_q;
  assign o_slot_err    = slot_err_q;
  assign o_drop_count  = drop_count_q;

endmodule

// File: tb/tb_voice_update_scheduler.sv
// Directed scenarios plus a randomized run checked against an event-level
// reference model of the scheduler.
module tb_voice_update_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag = 1'b0;
  logic        status = 1'b0;
  logic [7:0]  vidx = '0;
  logic [31:0] tuning = '0;
  logic [6:0]  vel = '0;
  logic        slot_valid = 1'b0;
  logic [3:0]  slot_voice = '0;

  logic        o_wr_en, o_wr_gate, o_overflow, o_slot_err;
  logic [3:0]  o_wr_voice;
  logic [31:0] o_wr_tuning;
  logic [6:0]  o_wr_velocity;
  logic [15:0] o_gate_mask;
  logic [2:0]  o_fifo_level;
  logic [7:0]  o_drop_count;

  int tests = 0;
  int fails = 0;
  int slot_mode = 0;  // 0 = driven by tasks, 1 = rotating every cycle, 2 = random
  logic [3:0] rot = '0;

  voice_update_scheduler dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_SPI_flag(flag), .i_SPI_note_status(status), .i_SPI_voice_index(vidx),
    .i_SPI_tuning_code(tuning), .i_SPI_velocity(vel),
    .i_slot_valid(slot_valid), .i_slot_voice(slot_voice),
    .o_wr_en(o_wr_en), .o_wr_voice(o_wr_voice), .o_wr_tuning(o_wr_tuning),
    .o_wr_velocity(o_wr_velocity), .o_wr_gate(o_wr_gate),
    .o_gate_mask(o_gate_mask), .o_fifo_level(o_fifo_level),
    .o_overflow(o_overflow), .o_slot_err(o_slot_err), .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (slot_mode == 1) begin
      slot_valid = 1'b1;
      slot_voice = rot;
      rot = rot + 4'd1;
    end else if (slot_mode == 2) begin
      slot_valid = 1'($urandom_range(0, 1));
      slot_voice = 4'($urandom_range(0, 15));
    end
  end

  // Reference model: arrival queue, one held event, gate/sticky bookkeeping.
  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] t;
    logic [6:0]  vel;
    logic        g;
  } ev_t;

  ev_t         mq[$];
  ev_t         m_hold;
  bit          m_busy = 0, m_writing = 0, m_flag_prev = 0, m_ovf = 0, m_serr = 0;
  int          m_pulses = 0, m_drops = 0;
  logic [15:0] m_mask = '0;
  ev_t         m_wr = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit  ev;
    ev_t e;
    if (!rst_n) begin
      mq.delete();
      m_hold = '0; m_busy = 0; m_writing = 0; m_flag_prev = 0;
      m_ovf = 0; m_serr = 0; m_pulses = 0; m_drops = 0; m_mask = '0; m_wr = '0;
    end else begin
      ev = flag && !m_flag_prev;
      m_flag_prev = flag;
      if (m_writing) begin
        m_mask[m_hold.v] = m_hold.g;
        m_writing = 0;
        m_busy = 0;
      end else if (m_busy) begin
        if (slot_valid) begin
          m_pulses++;
          if (slot_voice == m_hold.v || m_pulses == 17) begin
            if (slot_voice != m_hold.v) m_serr = 1;
            m_writing = 1;
            m_wr = m_hold;
          end
        end
      end else if (mq.size() > 0) begin
        m_hold = mq.pop_front();
        m_busy = 1;
        m_pulses = 0;
      end
      if (ev) begin
        if (vidx >= 16 || mq.size() == 4) begin
          if (vidx < 16) m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          e.v = vidx[3:0];
          e.g = status;
          e.t = status ? tuning : 32'd0;
          e.vel = status ? vel : 7'd0;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    slot_mode = 0; slot_valid = 0; flag = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic send_event(input logic st, input logic [7:0] v, input logic [31:0] t,
                            input logic [6:0] ve);
    status = st; vidx = v; tuning = t; vel = ve; flag = 1;
    @(negedge clk);
    flag = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %0b want 0", o_wr_en); end
    tests++; if (o_wr_voice !== 4'd0) begin fails++; $display("FAIL reset_wr_voice got %0d want 0", o_wr_voice); end
    tests++; if (o_wr_tuning !== 32'd0) begin fails++; $display("FAIL reset_wr_tuning got %h want 0", o_wr_tuning); end
    tests++; if (o_gate_mask !== 16'd0) begin fails++; $display("FAIL reset_mask got %h want 0", o_gate_mask); end
    tests++; if (o_fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", o_fifo_level); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b want 0", o_overflow); end
    tests++; if (o_slot_err !== 1'b0) begin fails++; $display("FAIL reset_slot_err got %0b want 0", o_slot_err); end
    tests++; if (o_drop_count !== 8'd0) begin fails++; $display("FAIL reset_drops got %0d want 0", o_drop_count); end
  endtask

  task automatic test_note_on();
    int writes = 0;
    send_event(1'b1, 8'd3, 32'h0001_0000, 7'd100);
    for (int v = 0; v < 16; v++) begin
      slot_valid = 1; slot_voice = 4'(v);
      @(negedge clk);
      if (o_wr_en === 1'b1) writes++;
      tests++;
      if (o_wr_en !== (v == 3)) begin
        fails++; $display("FAIL note_on_wr_en after slot %0d got %0b want %0b", v, o_wr_en, (v == 3));
      end
      if (v == 3) begin
        tests++;
        if ({o_wr_voice, o_wr_tuning, o_wr_velocity, o_wr_gate} !== {4'd3, 32'h0001_0000, 7'd100, 1'b1}) begin
          fails++; $display("FAIL note_on_payload got v=%0d t=%h vel=%0d g=%0b want v=3 t=00010000 vel=100 g=1",
                            o_wr_voice, o_wr_tuning, o_wr_velocity, o_wr_gate);
        end
      end
    end
    slot_valid = 0;
    @(negedge clk);
    tests++; if (writes != 1) begin fails++; $display("FAIL note_on_write_count got %0d want 1", writes); end
    tests++; if (o_gate_mask !== 16'h0008) begin fails++; $display("FAIL note_on_mask got %h want 0008", o_gate_mask); end
  endtask

  task automatic test_note_off_latency();
    status = 0; vidx = 8'd3; tuning = 32'hFFFF_FFFF; vel = 7'd50; flag = 1;
    @(negedge clk);
    tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL latency_n1 got %0b want 0", o_wr_en); end
    flag = 0;
    @(negedge clk);
    tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL latency_n2 got %0b want 0", o_wr_en); end
    slot_valid = 1; slot_voice = 4'd3;
    @(negedge clk);
    slot_valid = 0;
    tests++; if (o_wr_en !== 1'b1) begin fails++; $display("FAIL latency_n3 got %0b want 1", o_wr_en); end
    tests++;
    if ({o_wr_voice, o_wr_tuning, o_wr_velocity, o_wr_gate} !== {4'd3, 32'd0, 7'd0, 1'b0}) begin
      fails++; $display("FAIL note_off_payload got v=%0d t=%h vel=%0d g=%0b want v=3 t=0 vel=0 g=0",
                        o_wr_voice, o_wr_tuning, o_wr_velocity, o_wr_gate);
    end
    @(negedge clk);
    tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL note_off_single got %0b want 0", o_wr_en); end
    tests++; if (o_gate_mask !== 16'h0000) begin fails++; $display("FAIL note_off_mask got %h want 0000", o_gate_mask); end
  endtask

  task automatic test_bad_index();
    int writes = 0;
    send_event(1'b1, 8'd20, 32'h1234, 7'd9);
    tests++; if (o_fifo_level !== 3'd0) begin fails++; $display("FAIL bad_idx_level got %0d want 0", o_fifo_level); end
    tests++; if (o_drop_count !== 8'd1) begin fails++; $display("FAIL bad_idx_drops got %0d want 1", o_drop_count); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL bad_idx_overflow got %0b want 0", o_overflow); end
    slot_mode = 1;
    repeat (40) begin
      @(negedge clk);
      if (o_wr_en === 1'b1) writes++;
    end
    slot_mode = 0; slot_valid = 0;
    tests++; if (writes != 0) begin fails++; $display("FAIL bad_idx_writes got %0d want 0", writes); end
  endtask

  task automatic test_overflow();
    logic [3:0] order [5];
    logic [3:0] got [$];
    int cyc = 0;
    order = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    apply_reset();
    for (int k = 0; k < 5; k++) send_event(1'b1, 8'(order[k]), 32'(k + 1), 7'(k + 10));
    tests++; if (o_fifo_level !== 3'd4) begin fails++; $display("FAIL ovf_level_full got %0d want 4", o_fifo_level); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %0b want 0", o_overflow); end
    send_event(1'b1, 8'd7, 32'd99, 7'd99);
    tests++; if (o_fifo_level !== 3'd4) begin fails++; $display("FAIL ovf_level_after got %0d want 4", o_fifo_level); end
    tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %0b want 1", o_overflow); end
    tests++; if (o_drop_count !== 8'd1) begin fails++; $display("FAIL ovf_drops got %0d want 1", o_drop_count); end
    slot_mode = 1;
    while (got.size() < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (o_wr_en === 1'b1) got.push_back(o_wr_voice);
    end
    repeat (20) begin
      @(negedge clk);
      if (o_wr_en === 1'b1) got.push_back(o_wr_voice);
    end
    slot_mode = 0; slot_valid = 0;
    tests++; if (got.size() != 5) begin fails++; $display("FAIL ovf_drain_count got %0d want 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      tests++;
      if (got[k] !== order[k]) begin fails++; $display("FAIL ovf_order[%0d] got %0d want %0d", k, got[k], order[k]); end
    end
    tests++; if (o_fifo_level !== 3'd0) begin fails++; $display("FAIL ovf_drained_level got %0d want 0", o_fifo_level); end
  endtask

  task automatic test_slot_timeout();
    @(negedge clk);
    tests++; if (o_slot_err !== 1'b0) begin fails++; $display("FAIL tmo_pre_err got %0b want 0", o_slot_err); end
    send_event(1'b1, 8'd5, 32'hCAFE_0005, 7'd77);
    for (int p = 1; p <= 17; p++) begin
      slot_valid = 1; slot_voice = 4'd0;
      @(negedge clk);
      slot_valid = 0;
      tests++;
      if (o_wr_en !== (p == 17)) begin fails++; $display("FAIL tmo_wr_en pulse %0d got %0b want %0b", p, o_wr_en, (p == 17)); end
      if (p == 17) begin
        tests++; if (o_wr_voice !== 4'd5) begin fails++; $display("FAIL tmo_voice got %0d want 5", o_wr_voice); end
        tests++; if (o_slot_err !== 1'b1) begin fails++; $display("FAIL tmo_err got %0b want 1", o_slot_err); end
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    send_event(1'b1, 8'd9, 32'd9, 7'd9);
    send_event(1'b1, 8'd10, 32'd10, 7'd10);
    send_event(1'b1, 8'd11, 32'd11, 7'd11);
    tests++; if (o_fifo_level !== 3'd2) begin fails++; $display("FAIL mid_level got %0d want 2", o_fifo_level); end
    #2 rst_n = 0;
    #1;
    tests++; if (o_gate_mask !== 16'd0) begin fails++; $display("FAIL mid_mask got %h want 0", o_gate_mask); end
    tests++; if (o_fifo_level !== 3'd0) begin fails++; $display("FAIL mid_level0 got %0d want 0", o_fifo_level); end
    tests++; if (o_slot_err !== 1'b0) begin fails++; $display("FAIL mid_slot_err got %0b want 0", o_slot_err); end
    tests++; if (o_wr_voice !== 4'd0) begin fails++; $display("FAIL mid_wr_voice got %0d want 0", o_wr_voice); end
    tests++; if (o_wr_en !== 1'b0) begin fails++; $display("FAIL mid_wr_en got %0b want 0", o_wr_en); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    slot_mode = 1;
    repeat (60) begin
      @(negedge clk);
      if (o_wr_en === 1'b1) writes++;
    end
    slot_mode = 0; slot_valid = 0;
    tests++; if (writes != 0) begin fails++; $display("FAIL mid_post_writes got %0d want 0", writes); end
  endtask

  task automatic test_random();
    slot_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      flag   = 1'($urandom_range(0, 1));
      status = 1'($urandom_range(0, 1));
      vidx   = 8'($urandom_range(0, 19));
      tuning = $urandom;
      vel    = 7'($urandom_range(0, 127));
      @(negedge clk);
      tests++; if (o_wr_en !== m_writing) begin fails++; $display("FAIL rnd_wr_en c=%0d got %0b want %0b", c, o_wr_en, m_writing); end
      tests++;
      if ({o_wr_voice, o_wr_tuning, o_wr_velocity, o_wr_gate} !== m_wr) begin
        fails++; $display("FAIL rnd_payload c=%0d got %h want %h", c,
                          {o_wr_voice, o_wr_tuning, o_wr_velocity, o_wr_gate}, m_wr);
      end
      tests++; if (o_gate_mask !== m_mask) begin fails++; $display("FAIL rnd_mask c=%0d got %h want %h", c, o_gate_mask, m_mask); end
      tests++; if (o_fifo_level !== 3'(mq.size())) begin fails++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, o_fifo_level, mq.size()); end
      tests++; if (o_overflow !== m_ovf) begin fails++; $display("FAIL rnd_overflow c=%0d got %0b want %0b", c, o_overflow, m_ovf); end
      tests++; if (o_slot_err !== m_serr) begin fails++; $display("FAIL rnd_slot_err c=%0d got %0b want %0b", c, o_slot_err, m_serr); end
      tests++; if (o_drop_count !== 8'(m_drops)) begin fails++; $display("FAIL rnd_drops c=%0d got %0d want %0d", c, o_drop_count, m_drops); end
    end
    slot_mode = 0; slot_valid = 0; flag = 0;
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_note_on();
    test_note_off_latency();
    test_bad_index();
    test_overflow();
    test_slot_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
